// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR output decimator slice:
//   FIR_DATA_W     - width of the Q1.15 FIR output sample
//   state_t        - decimator control state (warm-up discard / running)
//   addr_w()       - address width needed to index a FIFO of a given depth
//   FIR_FIFO_AW    - address width of the default 8-entry output FIFO
// ---------------------------------------------------------------------------
package fir_pkg;

    localparam int FIR_DATA_W     = 16;
    localparam int FIR_FIFO_DEPTH = 8;

    typedef enum logic {
        ST_WARMUP,
        ST_RUN
    } state_t;

    // Never returns 0 so that a 1-entry request still yields a legal slice.
    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int FIR_FIFO_AW = addr_w(FIR_FIFO_DEPTH);

endpackage

// File: rtl/fir_out_fifo.sv
// ---------------------------------------------------------------------------
// fir_out_fifo
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-low reset (empties the FIFO)
//   push       - write push_data this cycle (ignored when full without pop)
//   push_data  - sample to write
//   pop        - remove the head entry this cycle (ignored when empty)
//   data       - head entry, forced to zero while empty
//   empty      - no entries stored
//   full       - DEPTH entries stored
//   level      - current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int DATA_W = FIR_DATA_W,
    parameter int DEPTH  = FIR_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // The extra MSB on each pointer counts laps, which separates full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: stale entries are never visible while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fir_out_decimator.sv
// ---------------------------------------------------------------------------
// fir_out_decimator
// Drops the FIR pipeline-fill samples, keeps one sample in DECIM and buffers
// the kept samples in a FWFT FIFO drained over valid/ready.
// Ports:
//   clk         - rising-edge clock
//   rst         - asynchronous active-low reset
//   enable      - sample strobe shared with the FIR
//   y_in        - FIR output sample
//   clear       - synchronous clear of overflow / drop_count
//   m_data      - head-of-FIFO sample
//   m_valid     - FIFO not empty
//   m_ready     - consumer takes m_data this cycle
//   fifo_level  - FIFO occupancy
//   overflow    - sticky flag, a kept sample was lost to a full FIFO
//   drop_count  - number of lost samples, saturating
// ---------------------------------------------------------------------------
module fir_out_decimator
    import fir_pkg::*;
#(
    parameter int DATA_W     = FIR_DATA_W,
    parameter int DECIM      = 4,
    parameter int PHASE      = 0,
    parameter int WARMUP     = 9,
    parameter int FIFO_DEPTH = FIR_FIFO_DEPTH,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [DATA_W-1:0]             y_in,
    input  logic                          clear,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [CNT_W-1:0]              drop_count
);

    // Widths sized with one spare code so WARMUP=0 / DECIM=1 stay legal.
    localparam int     WARM_W      = $clog2(WARMUP + 2);
    localparam int     PH_W        = $clog2(DECIM + 1);
    localparam state_t RESET_STATE = (WARMUP == 0) ? ST_RUN : ST_WARMUP;

    state_t            state;
    state_t            next_state;
    logic [WARM_W-1:0] warm_cnt;
    logic [PH_W-1:0]   phase;
    logic              keep;
    logic              drop;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;

    // State register plus the warm-up and phase counters; both counters only
    // move on accepted samples so a gap in enable freezes them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RESET_STATE;
            warm_cnt <= '0;
            phase    <= '0;
        end else begin
            state <= next_state;
            if (state == ST_WARMUP && enable) begin
                warm_cnt <= warm_cnt + WARM_W'(1);
            end
            if (state == ST_RUN && enable) begin
                phase <= (phase == PH_W'(DECIM - 1)) ? '0 : phase + PH_W'(1);
            end
        end
    end

    // Next-state and keep decision. The WARMUP-th accepted sample is still
    // discarded; the first sample seen in RUN sits at phase 0.
    always_comb begin
        next_state = state;
        keep       = 1'b0;
        case (state)
            ST_WARMUP: begin
                if (enable && warm_cnt == WARM_W'(WARMUP - 1)) next_state = ST_RUN;
            end
            ST_RUN: begin
                keep = enable && (phase == PH_W'(PHASE));
            end
            default: next_state = RESET_STATE;
        endcase
    end

    // A kept sample is lost only when the FIFO is full and nothing leaves.
    assign pop     = m_valid && m_ready;
    assign drop    = keep && full && !pop;
    assign push    = keep && !drop;
    assign m_valid = !empty;

    fir_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (y_in),
        .pop       (pop),
        .data      (m_data),
        .empty     (empty),
        .full      (full),
        .level     (fifo_level)
    );

    // Overflow status. A drop in the same cycle as clear wins over the clear
    // so no loss event goes unreported.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            overflow   <= drop;
            drop_count <= drop ? CNT_W'(1) : '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fir_out_decimator.sv
// ---------------------------------------------------------------------------
// tb_fir_out_decimator
// Directed bench for fir_out_decimator with DECIM=4, PHASE=0, WARMUP=9,
// FIFO_DEPTH=8. Each scenario task drives its own vectors and compares the
// outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_fir_out_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] y_in;
    logic        clear;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [15:0] drop_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fir_out_decimator #(
        .DATA_W     (16),
        .DECIM      (4),
        .PHASE      (0),
        .WARMUP     (9),
        .FIFO_DEPTH (8),
        .CNT_W      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .y_in       (y_in),
        .clear      (clear),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    // Advance one clock; outputs are then read 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [15:0] v);
        y_in   = v;
        enable = 1'b1;
        step();
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        enable  = 1'b0;
        clear   = 1'b0;
        m_ready = 1'b0;
        y_in    = '0;
        repeat (2) step();
        rst = 1'b1;
    endtask

    task automatic warmup();
        for (int i = 0; i < 9; i++) feed(16'(1000 + i));
        enable = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; clear = 1'b0; m_ready = 1'b1; y_in = 16'h1234;
        step();
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%0d want=0", m_valid); end
        total++; if (m_data !== 16'd0) begin bad++; $display("[TB] FAIL reset_data got=%0d want=0", m_data); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("[TB] FAIL reset_level got=%0d want=0", fifo_level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_overflow got=%0d want=0", overflow); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_drops got=%0d want=0", drop_count); end
        rst = 1'b1;
    endtask

    task automatic test_warmup_decim();
        logic exp_v;
        do_reset();
        m_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            feed(16'(i));
            exp_v = (i == 10) || (i == 14) || (i == 18);
            total++;
            if (m_valid !== exp_v) begin
                bad++; $display("[TB] FAIL decim_valid sample=%0d got=%0d want=%0d", i, m_valid, exp_v);
            end
            if (exp_v) begin
                total++;
                if (m_data !== 16'(i)) begin
                    bad++; $display("[TB] FAIL decim_data sample=%0d got=%0d want=%0d", i, m_data, i);
                end
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_overflow();
        do_reset();
        warmup();
        for (int k = 0; k < 40; k++) feed(16'(100 + k));
        enable = 1'b0;
        total++; if (fifo_level !== 4'd8) begin bad++; $display("[TB] FAIL ovf_level got=%0d want=8", fifo_level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL ovf_flag got=%0d want=1", overflow); end
        total++; if (drop_count !== 16'd2) begin bad++; $display("[TB] FAIL ovf_drops got=%0d want=2", drop_count); end
        m_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== 16'(100 + 4*j)) begin
                bad++; $display("[TB] FAIL ovf_drain idx=%0d got=%0d/%0d want=1/%0d", j, m_valid, m_data, 100 + 4*j);
            end
            step();
        end
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovf_drained_valid got=%0d want=0", m_valid); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("[TB] FAIL ovf_drained_level got=%0d want=0", fifo_level); end
        m_ready = 1'b0;
    endtask

    task automatic test_enable_gating();
        do_reset();
        warmup();
        m_ready = 1'b1;
        feed(16'd200);
        total++; if (m_valid !== 1'b1 || m_data !== 16'd200) begin bad++; $display("[TB] FAIL gate_first got=%0d/%0d want=1/200", m_valid, m_data); end
        feed(16'd201);
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL gate_pop got=%0d want=0", m_valid); end
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            y_in = 16'($urandom);
            step();
            total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL gate_idle cycle=%0d got=%0d want=0", c, m_valid); end
        end
        feed(16'd202);
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL gate_202 got=%0d want=0", m_valid); end
        feed(16'd203);
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL gate_203 got=%0d want=0", m_valid); end
        feed(16'd204);
        total++; if (m_valid !== 1'b1 || m_data !== 16'd204) begin bad++; $display("[TB] FAIL gate_resume got=%0d/%0d want=1/204", m_valid, m_data); end
        enable = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        warmup();
        for (int k = 0; k <= 28; k++) feed(16'(300 + k));
        total++; if (fifo_level !== 4'd8) begin bad++; $display("[TB] FAIL b2b_fill got=%0d want=8", fifo_level); end
        for (int k = 29; k <= 31; k++) feed(16'(300 + k));
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL b2b_no_ovf_pre got=%0d want=0", overflow); end
        m_ready = 1'b1;
        feed(16'd332);
        enable = 1'b0;
        total++; if (fifo_level !== 4'd8) begin bad++; $display("[TB] FAIL b2b_level got=%0d want=8", fifo_level); end
        total++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin bad++; $display("[TB] FAIL b2b_nodrop got=%0d/%0d want=0/0", overflow, drop_count); end
        for (int j = 0; j < 8; j++) begin
            total++;
            if (m_valid !== 1'b1 || m_data !== 16'(304 + 4*j)) begin
                bad++; $display("[TB] FAIL b2b_order idx=%0d got=%0d/%0d want=1/%0d", j, m_valid, m_data, 304 + 4*j);
            end
            step();
        end
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_empty got=%0d want=0", m_valid); end
        m_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        warmup();
        for (int k = 0; k <= 36; k++) feed(16'(400 + k));
        enable  = 1'b0;
        m_ready = 1'b1;
        repeat (3) step();
        m_ready = 1'b0;
        total++; if (fifo_level !== 4'd5 || overflow !== 1'b1) begin bad++; $display("[TB] FAIL arst_pre got=%0d/%0d want=5/1", fifo_level, overflow); end
        #3 rst = 1'b0;
        #1;
        total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_valid got=%0d want=0", m_valid); end
        total++; if (fifo_level !== 4'd0) begin bad++; $display("[TB] FAIL arst_level got=%0d want=0", fifo_level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL arst_overflow got=%0d want=0", overflow); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL arst_drops got=%0d want=0", drop_count); end
        total++; if (m_data !== 16'd0) begin bad++; $display("[TB] FAIL arst_data got=%0d want=0", m_data); end
        step();
        rst     = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            feed(16'(500 + i));
            total++; if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL arst_warm sample=%0d got=%0d want=0", i, m_valid); end
        end
        feed(16'd509);
        total++; if (m_valid !== 1'b1 || m_data !== 16'd509) begin bad++; $display("[TB] FAIL arst_first got=%0d/%0d want=1/509", m_valid, m_data); end
        enable = 1'b0;
    endtask

    task automatic test_clear_drop();
        do_reset();
        warmup();
        for (int k = 0; k <= 36; k++) feed(16'(600 + k));
        total++; if (drop_count !== 16'd2) begin bad++; $display("[TB] FAIL clr_pre got=%0d want=2", drop_count); end
        for (int k = 37; k <= 39; k++) feed(16'(600 + k));
        clear = 1'b1;
        feed(16'd640);
        clear = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL clr_drop_flag got=%0d want=1", overflow); end
        total++; if (drop_count !== 16'd1) begin bad++; $display("[TB] FAIL clr_drop_count got=%0d want=1", drop_count); end
        total++; if (fifo_level !== 4'd8 || m_data !== 16'd600) begin bad++; $display("[TB] FAIL clr_fifo got=%0d/%0d want=8/600", fifo_level, m_data); end
        clear = 1'b1;
        feed(16'd641);
        clear = 1'b0;
        enable = 1'b0;
        total++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin bad++; $display("[TB] FAIL clr_plain got=%0d/%0d want=0/0", overflow, drop_count); end
        total++; if (fifo_level !== 4'd8) begin bad++; $display("[TB] FAIL clr_keeps_fifo got=%0d want=8", fifo_level); end
    endtask

    // Scenario sequence; every task restores reset state itself.
    initial begin
        rst = 1'b0; enable = 1'b0; clear = 1'b0; m_ready = 1'b0; y_in = '0;
        test_reset();
        test_warmup_decim();
        test_overflow();
        test_enable_gating();
        test_back_to_back();
        test_async_reset();
        test_clear_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_out_decimator.md
Name: fir_out_decimator

Overview:
Downstream stage of nfir_16tap. Takes the 16-bit Q1.15 FIR output stream, qualified by the same enable strobe, and discards the pipeline-fill warm-up samples. It then decimates by DECIM and buffers the kept samples in a small FWFT FIFO. The buffered samples drain to the next consumer over a valid/ready handshake, and overflow is reported through sticky and counter status.

Parameters:
DATA_W, 16, sample width (Q1.15, pass-through, no arithmetic on data)
DECIM, 4, decimation factor (>=1); DECIM=1 keeps every sample
PHASE, 0, kept phase index, 0..DECIM-1
WARMUP, 9, accepted samples discarded after reset (covers FIR pipeline fill); 0 = start in RUN
FIFO_DEPTH, 8, FIFO entries, power of 2, >=2
CNT_W, 16, drop counter width

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
enable  in  1  sample strobe, same signal that drives nfir_16tap enable
y_in  in  DATA_W  FIR output sample (nfir_16tap y_out)
clear  in  1  synchronous clear of overflow/drop_count
m_data  out  DATA_W  head-of-FIFO sample
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data this cycle
fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky: a kept sample was dropped
drop_count  out  CNT_W  dropped-sample count, saturates at all-ones

Behaviour:
- Reset (rst=0, async): state=WARMUP (RUN if WARMUP=0), warm-up count=0, phase=0, FIFO empty. Outputs: m_valid=0, m_data=0, fifo_level=0, overflow=0, drop_count=0.
- Accepted sample: rst high and enable=1 at a rising edge.
- FSM WARMUP: each accepted sample increments the warm-up count and is not pushed. The WARMUP-th accepted sample moves the FSM to RUN.
- FSM RUN: each accepted sample advances phase 0..DECIM-1 with wrap. The sample is pushed when phase==PHASE before the increment. The first sample accepted in RUN has phase 0.
- enable=0: warm-up count, phase and pushes are frozen. The drain side is independent of enable.
- FIFO is first-word-fall-through: m_valid = not empty, and m_data = oldest entry. Pop happens when m_valid and m_ready.
- Latency: a kept sample written at edge N is visible on m_data/m_valid after edge N. There is no combinational y_in->m_data bypass.
- Full, push, no pop: the new sample is dropped, overflow is set to 1, and drop_count increments (saturating). The FIFO contents are unchanged.
- Full, push and pop in the same cycle: the push is accepted, there is no drop, and the level is unchanged.
- Empty with pop requested: impossible, because m_valid=0.
- Push and pop on a non-full FIFO: level unchanged, and order is preserved.
- Pointers wrap modulo FIFO_DEPTH. An extra pointer bit distinguishes full from empty.
- clear=1: overflow<=0 and drop_count<=0. If a drop occurs in the same cycle, the event is retained: overflow=1, drop_count=1. clear does not touch the FIFO, the FSM or the phase.
- m_data, m_valid and fifo_level are registered or derived from registered state only.
- Reset asserted mid-operation: everything returns to reset values immediately, and warm-up restarts on release.

Decomposition:
- Package fir_pkg: FIR_DATA_W=16; state typedef {WARMUP, RUN}; a clog2-based address-width helper constant.
- Sub-module fir_out_fifo: sync FWFT FIFO with DATA_W and DEPTH parameters. Ports: clk, rst, push, push_data, pop, data, empty, full, level.
- The top level holds the FSM, the phase counter, drop logic and status.

Test Plan:
1. Warm-up and decimation: release reset, m_ready=1, drive y_in=1..20 with enable=1 every cycle. Required: y_in 1..9 are discarded, and m_data sequence is 10,14,18. Each m_valid pulse rises the cycle after the accepting edge.
2. Overflow: after warm-up, set m_ready=0 and push 40 samples (10 kept). Required: fifo_level=8, overflow=1, drop_count=2. Then set m_ready=1; the first 8 kept values drain in order and m_valid falls after the 8th.
3. Enable gating: hold enable=0 for 10 cycles with random y_in mid-stream. Required: no pushes and phase frozen. On resume, the next kept sample is exactly the DECIM-th accepted sample counted across the gap.
4. Full with simultaneous push/pop: fill to 8, then a kept sample arrives with m_ready=1. Required: level stays 8, no drop, and order is correct.
5. Async reset mid-stream with level=5 and overflow=1: assert rst=0 between edges. Required: m_valid=0, fifo_level=0, overflow=0 and drop_count=0 immediately. The next 9 samples after release are discarded.
6. clear coinciding with a drop: FIFO full, m_ready=0, clear=1 on the dropping edge. Required: overflow=1, drop_count=1 afterwards. A later clear with no drop gives overflow=0, drop_count=0.
